// File: rtl/shift_out_serializer_if.sv
// Handshake and serial-stream bundle for shift_out_serializer.
// master: word producer / stream observer; slave: the serializer itself.
interface shift_out_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] data_in;
    logic             ready;
    logic             serial_out;
    logic             serial_valid;
    logic             done;

    modport master (
        output load, data_in,
        input  ready, serial_out, serial_valid, done
    );

    modport slave (
        input  load, data_in,
        output ready, serial_out, serial_valid, done
    );
endinterface

// File: rtl/shift_out_serializer.sv
// Parallel-to-serial shifter, MSB first, with one-cycle done pulse.
// Optional trailing even-parity bit: define SHIFT_OUT_SERIALIZER_PARITY_EN.
module shift_out_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    shift_out_serializer_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
`ifdef SHIFT_OUT_SERIALIZER_PARITY_EN
        S_PARITY = 2'd2,
`endif
        S_SHIFT  = 2'd1
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               so_q, so_d;
    logic               sv_q, sv_d;
    logic               done_q, done_d;
`ifdef SHIFT_OUT_SERIALIZER_PARITY_EN
    logic               parity_q, parity_d;
`endif

    // State and output registers; reset abandons any word in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            so_q     <= 1'b0;
            sv_q     <= 1'b0;
            done_q   <= 1'b0;
`ifdef SHIFT_OUT_SERIALIZER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            so_q     <= so_d;
            sv_q     <= sv_d;
            done_q   <= done_d;
`ifdef SHIFT_OUT_SERIALIZER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next state and next registered outputs; serial_out_d is the bit shown next cycle.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        ready_d  = 1'b0;
        so_d     = 1'b0;
        sv_d     = 1'b0;
        done_d   = 1'b0;
`ifdef SHIFT_OUT_SERIALIZER_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.load && ready_q) begin
                    state_d  = S_SHIFT;
                    shreg_d  = bus.data_in;
                    cnt_d    = '0;
                    so_d     = bus.data_in[WIDTH-1];
                    sv_d     = 1'b1;
`ifdef SHIFT_OUT_SERIALIZER_PARITY_EN
                    parity_d = ^bus.data_in;
`endif
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SHIFT_OUT_SERIALIZER_PARITY_EN
                    state_d = S_PARITY;
                    so_d    = parity_q;
                    sv_d    = 1'b1;
`else
                    state_d = S_IDLE;
                    ready_d = 1'b1;
                    done_d  = 1'b1;
`endif
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    so_d    = shreg_q[WIDTH-2];
                    sv_d    = 1'b1;
                end
            end
`ifdef SHIFT_OUT_SERIALIZER_PARITY_EN
            S_PARITY: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
                done_d  = 1'b1;
            end
`endif
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    assign bus.ready        = ready_q;
    assign bus.serial_out   = so_q;
    assign bus.serial_valid = sv_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_shift_out_serializer.sv
// Self-checking bench for shift_out_serializer (WIDTH=8).
// Expected stream per accepted word w: cycles 1..W carry w[W-c], then an
// optional even-parity cycle, then one done/ready cycle.
module tb_shift_out_serializer;
    localparam int unsigned W = 8;
`ifdef SHIFT_OUT_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    shift_out_serializer_if #(.WIDTH(W)) bus ();

    shift_out_serializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic so, input logic sv,
                           input logic rdy, input logic dn);
        chk({tag, ".serial_out"},   bus.serial_out,   so);
        chk({tag, ".serial_valid"}, bus.serial_valid, sv);
        chk({tag, ".ready"},        bus.ready,        rdy);
        chk({tag, ".done"},         bus.done,         dn);
    endtask

    // Entry: at a negedge with load=1/data_in=w already applied.
    // noise_cycle: 0 none, -1 load=1 with random data every busy cycle,
    // >0 load=1 with noise_word in that cycle only. Returns in the done cycle.
    task automatic serialize(input logic [W-1:0] w, input int noise_cycle,
                             input logic [W-1:0] noise_word, input string tag);
        logic par_bit;
        par_bit = 1'($countones(w) % 2);
        for (int c = 1; c <= int'(W) + PAR + 1; c++) begin
            @(negedge clk);
            bus.load    = 1'b0;
            bus.data_in = W'($urandom);
            if (c <= int'(W) + PAR) begin
                if (noise_cycle < 0) begin
                    bus.load = 1'b1;
                end else if (noise_cycle == c) begin
                    bus.load    = 1'b1;
                    bus.data_in = noise_word;
                end
            end
            if (c <= int'(W))
                chk_out($sformatf("%s.bit%0d", tag, c), w[int'(W) - c], 1'b1, 1'b0, 1'b0);
            else if (c <= int'(W) + PAR)
                chk_out({tag, ".parity"}, par_bit, 1'b1, 1'b0, 1'b0);
            else
                chk_out({tag, ".done"}, 1'b0, 1'b0, 1'b1, 1'b1);
        end
    endtask

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] nw;
        int           gap;

        rst         = 1'b0;
        bus.load    = 1'b0;
        bus.data_in = '0;
        @(negedge clk);
        chk_out("reset", 1'b0, 1'b0, 1'b1, 1'b0);

        // Load accepted at the first edge after reset release.
        rst         = 1'b1;
        bus.load    = 1'b1;
        bus.data_in = 8'hA5;
        serialize(8'hA5, 0, 8'h00, "a5");

        // Accepted in the done cycle; FF offered mid-word must be ignored.
        bus.load    = 1'b1;
        bus.data_in = 8'h3C;
        serialize(8'h3C, 3, 8'hFF, "3c");

        // Load held high across back-to-back words.
        bus.load    = 1'b1;
        bus.data_in = 8'h81;
        serialize(8'h81, -1, 8'h00, "81");
        bus.load    = 1'b1;
        bus.data_in = 8'h42;
        serialize(8'h42, -1, 8'h00, "42");
        bus.load    = 1'b0;
        @(negedge clk);
        chk_out("idle", 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-word: stream dropped immediately, no done pulse.
        bus.load    = 1'b1;
        bus.data_in = 8'hF0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            bus.load = 1'b0;
            chk_out($sformatf("f0.bit%0d", c), 1'b1, 1'b1, 1'b0, 1'b0);
        end
        #2 rst = 1'b0;
        #1 chk_out("abort", 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk_out("in_reset", 1'b0, 1'b0, 1'b1, 1'b0);
        rst         = 1'b1;
        bus.load    = 1'b1;
        bus.data_in = 8'h0F;
        serialize(8'h0F, 0, 8'h00, "0f");

        // Parity-sensitive words (odd and even number of ones).
        bus.load    = 1'b1;
        bus.data_in = 8'h07;
        serialize(8'h07, 0, 8'h00, "07");
        bus.load    = 1'b1;
        bus.data_in = 8'h03;
        serialize(8'h03, 0, 8'h00, "03");
        bus.load    = 1'b0;
        @(negedge clk);
        chk_out("post03", 1'b0, 1'b0, 1'b1, 1'b0);

        // Random words, random busy-time noise, random chaining or idle gaps.
        w           = W'($urandom);
        bus.load    = 1'b1;
        bus.data_in = w;
        for (int k = 0; k < 12; k++) begin
            serialize(w, ($urandom_range(1, 0) == 1) ? -1 : 0, 8'h00,
                      $sformatf("rnd%0d", k));
            nw = W'($urandom);
            if ($urandom_range(1, 0) == 0) begin
                gap = int'($urandom_range(3, 1));
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    chk_out($sformatf("gap%0d", k), 1'b0, 1'b0, 1'b1, 1'b0);
                end
            end
            bus.load    = 1'b1;
            bus.data_in = nw;
            w           = nw;
        end
        bus.load = 1'b0;
        @(negedge clk);
        chk_out("final", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_out_serializer.md
SHIFT_OUT_SERIALIZER -- requirements
Module: shift_out_serializer

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, parallel word width in bits (legal range 2..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock; the only clock.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: load  input  1  word-transfer request; qualified by ready.
REQ-005 SHALL have port: data_in  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port: ready  output  1  high when idle and able to accept a word.
REQ-007 SHALL have port: serial_out  output  1  serial data bit, MSB first.
REQ-008 SHALL have port: serial_valid  output  1  high while serial_out carries a data or parity bit.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking word completion.

Function
REQ-010 SHALL implement states IDLE, SHIFT and PARITY; all outputs registered.
REQ-011 SHALL accept a word at a rising edge where load=1 and ready=1: capture data_in, clear the bit counter, go to SHIFT, drive ready=0.
REQ-012 SHALL present data_in[WIDTH-1] on serial_out with serial_valid=1 in the cycle after acceptance; latency = 1 cycle.
REQ-013 SHALL present bits WIDTH-1 down to 0 on consecutive cycles, one bit per cycle, with serial_valid=1 throughout.
REQ-014 SHALL, after bit 0, go to IDLE, set done=1 and ready=1 for exactly that next cycle, with serial_valid=0 and serial_out=0 (parity disabled).
REQ-015 SHALL ignore load while ready=0; no capture, no change to the word in flight.
REQ-016 SHALL accept a new word in the cycle where done=1 if load=1; its first bit appears the following cycle; word period = WIDTH+1 cycles (WIDTH+2 with parity).
REQ-017 SHALL drive serial_out=0 and serial_valid=0 whenever in IDLE.
REQ-018 SHALL size the bit counter ceil(log2(WIDTH)) bits and terminate on count = WIDTH-1 with no wrap-around or extra bit.
REQ-019 SHALL hold done=0 in every cycle other than the single completion cycle.

Reset
REQ-020 SHALL, while rst=0, force immediately: state IDLE, ready=1, serial_out=0, serial_valid=0, done=0, shift register 0, counter 0.
REQ-021 SHALL abandon a word in flight when rst asserts mid-transfer; no done pulse for it.
REQ-022 SHALL accept load at the first rising edge after rst deasserts.

Configuration
REQ-023 SHALL use macro SHIFT_OUT_SERIALIZER_PARITY_EN to compile the PARITY state in or out.
REQ-024 SHALL, with the macro defined, follow bit 0 with one PARITY cycle: serial_out = XOR of the captured word (even parity), serial_valid=1; done/ready follow in the next cycle.
REQ-025 SHALL, with the macro undefined, contain no parity logic or state; behaviour per REQ-014.

Verification
REQ-026 SHALL cover: reset, then load=1 data_in=8'hA5 for one cycle -> serial_out 1,0,1,0,0,1,0,1 in cycles 1..8 with serial_valid=1; done=1 and ready=1 in cycle 9.
REQ-027 SHALL cover: data_in=8'h3C accepted; load=1 data_in=8'hFF applied in cycle 3 -> ignored; sequence stays 0,0,1,1,1,1,0,0.
REQ-028 SHALL cover: load held high with 8'h81 then 8'h42 -> second word starts in cycle 10 immediately after done; bits 0,1,0,0,0,0,1,0; done in cycles 9 and 18.
REQ-029 SHALL cover: rst=0 after 3 bits of 8'hF0 -> serial_valid=0, ready=1 at once; no done; next load of 8'h0F serializes cleanly.
REQ-030 SHALL cover: with SHIFT_OUT_SERIALIZER_PARITY_EN, data_in=8'h07 -> 8 data bits, parity bit 1 in cycle 9, done in cycle 10; 8'h03 -> parity bit 0.
